spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//   SPI target (mode 0) and configuration register file feeding pwm_peripheral.
//   Samples the external SPI pins in the clk domain, decodes 16-bit frames,
//   writes or reads nine 8-bit registers, and drives them as static outputs
//   to the PWM stage.
// PARAMETERS
//   NUM_REGS     9   implemented registers, addresses 0x00..NUM_REGS-1
//   ADDR_W       7   address field width in the frame
//   SYNC_STAGES  2   flops per input synchronizer (>=2)
// PORTS
//   clk                                  in   1  system clock
//   rst_n                                in   1  async active-low reset
//   sclk                                 in   1  SPI clock (async to clk)
//   copi                                 in   1  SPI data in
//   ncs                                  in   1  SPI chip select, active low
//   cipo                                 out  1  SPI data out
//   wr_strobe                            out  1  1-clk pulse on each committed write
//   reg_en_out                           out  8  addr 0x00
//   reg_en_pwm_out                       out  8  addr 0x01
//   reg_out_3_0_pwm_gen_channel          out  8  addr 0x02
//   reg_out_7_4_pwm_gen_channel          out  8  addr 0x03
//   reg_pwm_gen_0_ch_0_duty_cycle        out  8  addr 0x04
//   reg_pwm_gen_0_ch_1_duty_cycle        out  8  addr 0x05
//   reg_pwm_gen_1_ch_0_duty_cycle        out  8  addr 0x06
//   reg_pwm_gen_1_ch_1_duty_cycle        out  8  addr 0x07
//   reg_pwm_gen_1_0_frequency_divider    out  8  addr 0x08
// BEHAVIOUR
// - Clocking: one clock, clk. Reset: rst_n, asynchronous, active low.
// - Reset values:
//   - All registers and wr_strobe = 0. cipo = 0.
//   - Bit counter = 0.
//   - ncs synchronizer resets to 1 (deasserted).
// - Input sampling: sclk, copi and ncs pass through SYNC_STAGES flops. One more
//   flop on sclk forms the rise/fall detectors. Requirement: sclk <= clk/8.
// - Frame format, MSB first, 16 bits:
//   - bit15: R/W (1 = write)
//   - bits14:8: address
//   - bits7:0: data
// - COPI is sampled on each detected sclk rise while the synced ncs is low.
// - Frame FSM states IDLE -> SHIFT -> DONE:
//   - IDLE -> SHIFT on a synced ncs fall. Bit counter cleared.
//   - SHIFT: on each sclk rise, shift COPI into a 16-bit shift register and
//     increment the bit counter.
//   - On the 16th rise -> DONE.
//     - Write to an address below NUM_REGS: the register updates on the next
//       clk edge and wr_strobe pulses for 1 clk.
//     - Write to an address >= NUM_REGS: dropped, no wr_strobe.
//   - DONE: further sclk edges are ignored. A synced ncs rise -> IDLE.
//   - A synced ncs rise in SHIFT (fewer than 16 bits): frame discarded, -> IDLE,
//     no register change.
// - Read path (R/W = 0):
//   - After the 8th rise, latch register[addr] into an 8-bit output shifter.
//     An address >= NUM_REGS latches 0x00.
//   - On the following sclk fall, cipo = shifter[7].
//   - Each later fall shifts left, so data bits 7..0 are valid at rises 9..16.
//   - cipo = 0 in IDLE, on writes, and in DONE.
// - Total latency: the ncs and sclk synchronizer path (SYNC_STAGES + 2 clk),
//   counted from the 16th sclk rise to the register being visible.
// - Outputs: registers drive outputs directly and change only on committed
//   writes. Reads have no side effects.
// - Reset mid-frame: everything returns to reset values. Because the synced
//   ncs resets high, a frame already in flight is ignored. Decoding resumes
//   only after ncs is seen high and then low again.
// - Simultaneous rise and ncs rise in the same clk: the ncs rise wins, and the
//   frame is committed only if the count was already 16.
// STRUCTURE
// - Shared package spi_pwm_pkg holds:
//   - FRAME_BITS = 16
//   - register address localparams ADDR_EN_OUT = 0x00 .. ADDR_FREQ_DIV = 0x08
//   - FSM state encoding {IDLE, SHIFT, DONE}
// - Sub-module spi_sync_edge (parameter SYNC_STAGES): synchronizer plus rise/fall
//   pulse outputs. Instantiated for sclk and ncs; copi uses the plain synced
//   output only.
// - Top level holds the FSM, bit counter, input and output shifters, and the
//   register array.
// TESTING
// 1. Write 0x8000|0x00FF (addr 0x00, data 0xFF), full frame ->
//    reg_en_out = 0xFF, wr_strobe exactly 1 clk, all other regs 0.
// 2. Write addr 0x04 data 0x80, then read addr 0x04 ->
//    cipo shifts 1000_0000 on bits 8..15, reg unchanged, no wr_strobe.
// 3. Write addr 0x09 data 0x55 -> no register change, no wr_strobe;
//    a subsequent read of 0x09 returns 0x00.
// 4. ncs raised after 10 bits of a write to 0x08 -> register stays 0x00;
//    the next full frame decodes correctly.
// 5. 20 sclk cycles in one frame writing 0x02 = 0xE4 ->
//    only the first 16 bits are used; reg = 0xE4.
// 6. Assert rst_n low mid-frame with regs preloaded ->
//    all outputs 0 at once; the remaining bits of that frame are ignored.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// Shared constants for the SPI configuration front end of the PWM peripheral:
// frame geometry, register map and frame FSM encoding.
package spi_pwm_pkg;

    localparam int unsigned FRAME_BITS = 16;

    localparam int unsigned ADDR_EN_OUT      = 0;
    localparam int unsigned ADDR_EN_PWM_OUT  = 1;
    localparam int unsigned ADDR_OUT_3_0     = 2;
    localparam int unsigned ADDR_OUT_7_4     = 3;
    localparam int unsigned ADDR_G0_CH0_DUTY = 4;
    localparam int unsigned ADDR_G0_CH1_DUTY = 5;
    localparam int unsigned ADDR_G1_CH0_DUTY = 6;
    localparam int unsigned ADDR_G1_CH1_DUTY = 7;
    localparam int unsigned ADDR_FREQ_DIV    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } frame_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with one extra history flop
// producing single-cycle rise and fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        ResetVal    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target decoding 16-bit frames (R/W, address, data) into a bank of
// 8-bit configuration registers that statically drive the PWM stage.
module spi_reg_bank
    import spi_pwm_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 9,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic       wr_strobe,
    output logic [7:0] reg_en_out,
    output logic [7:0] reg_en_pwm_out,
    output logic [7:0] reg_out_3_0_pwm_gen_channel,
    output logic [7:0] reg_out_7_4_pwm_gen_channel,
    output logic [7:0] reg_pwm_gen_0_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_0_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_0_frequency_divider
);

    localparam int unsigned SettleCycles = SYNC_STAGES + 1;
    localparam int unsigned SettleW      = $clog2(SettleCycles + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic copi_s;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .ResetVal   (1'b0)
    ) u_sclk_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (sclk),
        .q_o   (sclk_s),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .ResetVal   (1'b1)
    ) u_ncs_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (ncs),
        .q_o   (ncs_s),
        .rise_o(ncs_rise),
        .fall_o(ncs_fall)
    );

    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    assign copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    assign copi_s      = copi_sync_q[SYNC_STAGES-1];

    frame_state_e          state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [7:0]            rd_shift_q, rd_shift_d;
    logic                  rd_active_q, rd_active_d;
    logic                  cipo_q, cipo_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [7:0]            regs_q [NUM_REGS];
    logic [7:0]            regs_d [NUM_REGS];
    logic [SettleW-1:0]    settle_q, settle_d;
    logic                  ncs_armed_q, ncs_armed_d;
    logic                  settle_done;
    logic [ADDR_W-1:0]     rd_addr, wr_addr;
    logic [7:0]            rd_val;
    logic                  wr_hit;

    // The ncs chain resets high, so a pin held low through reset shows up as a
    // spurious fall; frames start only once ncs has been genuinely seen high.
    assign settle_done = (settle_q == SettleW'(SettleCycles));

    always_comb begin
        settle_d    = settle_done ? settle_q : settle_q + 1'b1;
        ncs_armed_d = ncs_armed_q | (settle_done & ncs_s);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rd_shift_d  = rd_shift_q;
        rd_active_d = rd_active_q;
        cipo_d      = cipo_q;
        wr_strobe_d = 1'b0;
        regs_d      = regs_q;
        rd_addr     = '0;
        wr_addr     = '0;
        rd_val      = 8'h00;
        wr_hit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cipo_d = 1'b0;
                if (ncs_fall && ncs_armed_q) begin
                    state_d     = StShift;
                    bit_cnt_d   = '0;
                    rd_active_d = 1'b0;
                end
            end
            StShift: begin
                if (ncs_rise) begin
                    state_d = StIdle;
                    cipo_d  = 1'b0;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], copi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7 && !shift_d[ADDR_W]) begin
                        rd_addr = shift_d[ADDR_W-1:0];
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (rd_addr == ADDR_W'(i)) rd_val = regs_q[i];
                        end
                        rd_shift_d  = rd_val;
                        rd_active_d = 1'b1;
                    end
                    if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                        state_d = StDone;
                        if (shift_d[FRAME_BITS-1]) begin
                            wr_addr = shift_d[FRAME_BITS-2 -: ADDR_W];
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (wr_addr == ADDR_W'(i)) begin
                                    regs_d[i] = shift_d[7:0];
                                    wr_hit    = 1'b1;
                                end
                            end
                            wr_strobe_d = wr_hit;
                        end
                    end
                end else if (sclk_fall && rd_active_q) begin
                    cipo_d     = rd_shift_q[7];
                    rd_shift_d = {rd_shift_q[6:0], 1'b0};
                end
            end
            StDone: begin
                cipo_d = 1'b0;
                if (ncs_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_sync_q <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rd_shift_q  <= '0;
            rd_active_q <= 1'b0;
            cipo_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            settle_q    <= '0;
            ncs_armed_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            copi_sync_q <= copi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_shift_q  <= rd_shift_d;
            rd_active_q <= rd_active_d;
            cipo_q      <= cipo_d;
            wr_strobe_q <= wr_strobe_d;
            settle_q    <= settle_d;
            ncs_armed_q <= ncs_armed_d;
            regs_q      <= regs_d;
        end
    end

    assign cipo      = cipo_q;
    assign wr_strobe = wr_strobe_q;

    assign reg_en_out                        = regs_q[ADDR_EN_OUT];
    assign reg_en_pwm_out                    = regs_q[ADDR_EN_PWM_OUT];
    assign reg_out_3_0_pwm_gen_channel       = regs_q[ADDR_OUT_3_0];
    assign reg_out_7_4_pwm_gen_channel       = regs_q[ADDR_OUT_7_4];
    assign reg_pwm_gen_0_ch_0_duty_cycle     = regs_q[ADDR_G0_CH0_DUTY];
    assign reg_pwm_gen_0_ch_1_duty_cycle     = regs_q[ADDR_G0_CH1_DUTY];
    assign reg_pwm_gen_1_ch_0_duty_cycle     = regs_q[ADDR_G1_CH0_DUTY];
    assign reg_pwm_gen_1_ch_1_duty_cycle     = regs_q[ADDR_G1_CH1_DUTY];
    assign reg_pwm_gen_1_0_frequency_divider = regs_q[ADDR_FREQ_DIV];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: drives SPI frames on the pins, keeps a
// register model, and compares read-back bytes, strobe counts and outputs.
module tb_spi_reg_bank;

    localparam int Half = 8;  // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo, wr_strobe;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;

    int         n_checks = 0;
    int         n_fail = 0;
    int         strobe_cnt = 0;
    logic [7:0] exp_regs [9];
    logic [7:0] exp_rd_q [$];
    int         exp_strobe_q [$];

    spi_reg_bank dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .sclk                             (sclk),
        .copi                             (copi),
        .ncs                              (ncs),
        .cipo                             (cipo),
        .wr_strobe                        (wr_strobe),
        .reg_en_out                       (r0),
        .reg_en_pwm_out                   (r1),
        .reg_out_3_0_pwm_gen_channel      (r2),
        .reg_out_7_4_pwm_gen_channel      (r3),
        .reg_pwm_gen_0_ch_0_duty_cycle    (r4),
        .reg_pwm_gen_0_ch_1_duty_cycle    (r5),
        .reg_pwm_gen_1_ch_0_duty_cycle    (r6),
        .reg_pwm_gen_1_ch_1_duty_cycle    (r7),
        .reg_pwm_gen_1_0_frequency_divider(r8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return r0;
            1: return r1;
            2: return r2;
            3: return r3;
            4: return r4;
            5: return r5;
            6: return r6;
            7: return r7;
            default: return r8;
        endcase
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 9; i++) check_val($sformatf("%s_reg%0d", tag, i), dut_reg(i), exp_regs[i]);
        check_val({tag, "_cipo"}, cipo, 0);
        check_val({tag, "_strobe"}, wr_strobe, 0);
    endtask

    // Drives one frame of nbits clocks; bits past 16 are padding ones.
    task automatic spi_frame(input string tag, input logic [15:0] word, input int nbits);
        logic [7:0] cap;
        logic [7:0] exp_b;
        int         exp_s;
        int         addr;
        int         s0;
        cap   = 8'h00;
        exp_b = 8'h00;
        exp_s = 0;
        addr  = int'(word[14:8]);
        if (nbits >= 16) begin
            if (!word[15]) begin
                exp_b = (addr < 9) ? exp_regs[addr] : 8'h00;
            end else if (addr < 9) begin
                exp_regs[addr] = word[7:0];
                exp_s          = 1;
            end
        end
        exp_rd_q.push_back(exp_b);
        exp_strobe_q.push_back(exp_s);

        s0  = strobe_cnt;
        ncs = 1'b0;
        wait_clks(Half);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? word[15-i] : 1'b1;
            wait_clks(Half);
            if (i >= 8 && i < 16) cap = {cap[6:0], cipo};
            sclk = 1'b1;
            wait_clks(Half);
            sclk = 1'b0;
        end
        copi = 1'b0;
        wait_clks(Half);
        ncs = 1'b1;
        wait_clks(12);
        check_val({tag, "_rd"}, cap, exp_rd_q.pop_front());
        check_val({tag, "_strobe_clks"}, strobe_cnt - s0, exp_strobe_q.pop_front());
    endtask

    initial begin
        int s0;
        for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
        wait_clks(3);
        check_all("reset");
        rst_n = 1'b1;
        wait_clks(10);

        spi_frame("t1_wr0", 16'h80FF, 16);
        check_all("t1");

        spi_frame("t2_wr4", 16'h8480, 16);
        spi_frame("t2_rd4", 16'h0400, 16);
        spi_frame("t2_rd0", 16'h0000, 16);
        spi_frame("t2_wr1", 16'h813C, 16);
        spi_frame("t2_rd1", 16'h0100, 16);
        check_all("t2");

        spi_frame("t3_wr9", 16'h8955, 16);
        spi_frame("t3_rd9", 16'h0900, 16);
        check_all("t3");

        spi_frame("t4_part", 16'h88A5, 10);
        check_all("t4a");
        spi_frame("t4_full", 16'h88A5, 16);
        spi_frame("t4_rd8", 16'h0800, 16);
        check_all("t4b");

        spi_frame("t5_long", 16'h82E4, 20);
        spi_frame("t5_rd2", 16'h0200, 16);
        check_all("t5");

        // Reset in the middle of a write to addr 0; the tail must be ignored.
        s0  = strobe_cnt;
        ncs = 1'b0;
        wait_clks(Half);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w    = 16'h8011;
            copi = w[15-i];
            wait_clks(Half);
            sclk = 1'b1;
            wait_clks(Half);
            sclk = 1'b0;
            if (i == 4) begin
                rst_n = 1'b0;
                #2;
                for (int j = 0; j < 9; j++) exp_regs[j] = 8'h00;
                check_all("t6_inrst");
                wait_clks(3);
                rst_n = 1'b1;
            end
        end
        copi = 1'b0;
        wait_clks(Half);
        ncs = 1'b1;
        wait_clks(12);
        check_all("t6_after");
        check_val("t6_strobe_clks", strobe_cnt - s0, 0);
        spi_frame("t6_recover", 16'h8777, 16);
        spi_frame("t6_rd7", 16'h0700, 16);
        check_all("t6_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
